// File: rtl/mem_bus_decoder_pkg.sv
// Shared types, the default SoC memory map and the region match helper
// used by the memory bus decoder.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Default SoC memory map. Slave 0 is BRAM; UART and sysregs sit inside
  // the iomem window and win over it through their lower index.
  localparam logic [31:0] BRAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] SPI_NOR_BASE = 32'h0100_0000;
  localparam logic [31:0] SPI_NOR_MASK = 32'hFF00_0000;
  localparam logic [31:0] PSRAM_BASE   = 32'h0200_0000;
  localparam logic [31:0] PSRAM_MASK   = 32'hFF00_0000;
  localparam logic [31:0] UART_BASE    = 32'h0300_0000;
  localparam logic [31:0] UART_MASK    = 32'hFFFF_FFF0;
  localparam logic [31:0] SYSREG_BASE  = 32'h0300_0100;
  localparam logic [31:0] SYSREG_MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] IOMEM_BASE   = 32'h0300_0000;
  localparam logic [31:0] IOMEM_MASK   = 32'hFF00_0000;

  localparam int unsigned CPU_FREQ       = 50_000_000;
  localparam int unsigned SOC_NUM_SLAVES = 6;

  // Packed so that slave i occupies bits [i*32 +: 32].
  localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_BASE =
    {IOMEM_BASE, SYSREG_BASE, UART_BASE, PSRAM_BASE, SPI_NOR_BASE, BRAM_BASE};
  localparam logic [SOC_NUM_SLAVES*32-1:0] SOC_SLAVE_MASK =
    {IOMEM_MASK, SYSREG_MASK, UART_MASK, PSRAM_MASK, SPI_NOR_MASK, BRAM_MASK};
  // SPI NOR flash is execute/read only from the CPU's point of view.
  localparam logic [SOC_NUM_SLAVES-1:0] SOC_SLAVE_RO = 6'b000010;

  // Operands are widened to 64 bits so one helper serves any address width.
  function automatic logic region_match(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/mem_bus_decoder_if.sv
// Bus bundle between the CPU/memory side and the decoder. The master
// modport is the system side (CPU request, slave responses); the slave
// modport is the decoder, which answers the CPU and drives the slaves.
interface mem_bus_decoder_if #(
  parameter int unsigned NUM_SLAVES = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                             m_valid;
  logic                             m_ready;
  logic [ADDR_WIDTH-1:0]            m_addr;
  logic [DATA_WIDTH-1:0]            m_wdata;
  logic [DATA_WIDTH/8-1:0]          m_wstrb;
  logic [DATA_WIDTH-1:0]            m_rdata;
  logic                             m_err;
  logic [NUM_SLAVES-1:0]            s_valid;
  logic [NUM_SLAVES-1:0]            s_ready;
  logic [ADDR_WIDTH-1:0]            s_addr;
  logic [DATA_WIDTH-1:0]            s_wdata;
  logic [DATA_WIDTH/8-1:0]          s_wstrb;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata, m_err,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata, m_err,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );
endinterface

// File: rtl/mem_bus_decoder_addr_match.sv
// Combinational priority address decode: finds the lowest-index region
// that contains the address and flags writes into read-only regions.
module mem_bus_addr_match
  import mem_bus_pkg::*;
#(
  parameter int unsigned                      NUM_SLAVES = 6,
  parameter int unsigned                      ADDR_WIDTH = 32,
  parameter int unsigned                      DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter logic [NUM_SLAVES-1:0]            SLAVE_RO   = '0,
  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic                    o_hit,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_ro_violation
);

  // Scan from the highest index down so the lowest matching index is the
  // one left standing when regions overlap.
  always_comb begin
    logic [63:0] w_addr64;
    logic [63:0] w_base64;
    logic [63:0] w_mask64;
    o_hit    = 1'b0;
    o_index  = '0;
    w_addr64 = '0;
    w_base64 = '0;
    w_mask64 = '0;
    w_addr64[ADDR_WIDTH-1:0] = i_addr;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      w_base64 = '0;
      w_mask64 = '0;
      w_base64[ADDR_WIDTH-1:0] = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_mask64[ADDR_WIDTH-1:0] = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (region_match(w_addr64, w_base64, w_mask64)) begin
        o_hit   = 1'b1;
        o_index = IDX_W'(i);
      end
    end
  end

  // Any nonzero strobe is a write; only meaningful when a region was hit.
  always_comb begin
    o_ro_violation = 1'b0;
    if (o_hit && (|i_wstrb)) begin
      o_ro_violation = SLAVE_RO[o_index];
    end
  end

endmodule

// File: rtl/mem_bus_decoder.sv
// Registered memory-bus decoder between the CPU and its memory-mapped
// slaves: decodes the request, forwards it to one slave, returns a
// one-cycle response and reports unmapped, read-only and timeout errors.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int unsigned                      NUM_SLAVES     = 6,
  parameter int unsigned                      ADDR_WIDTH     = 32,
  parameter int unsigned                      DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK     = '0,
  parameter logic [NUM_SLAVES-1:0]            SLAVE_RO       = '0,
  parameter int unsigned                      TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0]            ERR_RDATA      = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  mem_bus_decoder_if.slave      bus,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_sel;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [NUM_SLAVES-1:0]   r_sValid;
  logic                    r_mReady;
  logic                    r_mErr;
  logic [DATA_WIDTH-1:0]   r_mRdata;
  logic [CNT_W-1:0]        r_timer;
  logic [7:0]              r_errCount;
  logic [ADDR_WIDTH-1:0]   r_errAddr;

  logic                    w_hit;
  logic [IDX_W-1:0]        w_index;
  logic                    w_roViolation;
  logic [NUM_SLAVES-1:0]   w_selOneHot;
  logic [DATA_WIDTH-1:0]   w_selRdata;

  mem_bus_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .SLAVE_RO   (SLAVE_RO)
  ) u_addrMatch (
    .i_addr         (bus.m_addr),
    .i_wstrb        (bus.m_wstrb),
    .o_hit          (w_hit),
    .o_index        (w_index),
    .o_ro_violation (w_roViolation)
  );

  // One-hot request vector for the slave chosen by the decode.
  always_comb begin
    w_selOneHot          = '0;
    w_selOneHot[w_index] = 1'b1;
  end

  assign w_selRdata = bus.s_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];

  // Transaction FSM: accept in IDLE, wait for the selected slave (or the
  // timeout) in ACTIVE, present the one-cycle response in RESP. m_valid is
  // deliberately ignored in RESP because the CPU still holds it high while
  // it sees m_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_sValid   <= '0;
      r_mReady   <= 1'b0;
      r_mErr     <= 1'b0;
      r_mRdata   <= '0;
      r_timer    <= '0;
      r_errCount <= '0;
      r_errAddr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mReady <= 1'b0;
          r_mErr   <= 1'b0;
          if (bus.m_valid) begin
            r_addr  <= bus.m_addr;
            r_wdata <= bus.m_wdata;
            r_wstrb <= bus.m_wstrb;
            r_sel   <= w_index;
            r_timer <= '0;
            if (!w_hit || w_roViolation) begin
              r_state  <= RESP;
              r_mReady <= 1'b1;
              r_mErr   <= 1'b1;
              r_mRdata <= ERR_RDATA;
            end else begin
              r_state  <= ACTIVE;
              r_sValid <= w_selOneHot;
            end
          end
        end
        ACTIVE: begin
          if (bus.s_ready[r_sel]) begin
            r_state  <= RESP;
            r_sValid <= '0;
            r_mReady <= 1'b1;
            r_mErr   <= 1'b0;
            r_mRdata <= w_selRdata;
          end else if ((TIMEOUT_CYCLES != 0) && (r_timer == TIMER_LAST)) begin
            r_state  <= RESP;
            r_sValid <= '0;
            r_mReady <= 1'b1;
            r_mErr   <= 1'b1;
            r_mRdata <= ERR_RDATA;
          end else begin
            r_timer <= r_timer + CNT_W'(1);
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_mReady <= 1'b0;
          r_mErr   <= 1'b0;
          if (r_mErr) begin
            r_errAddr <= r_addr;
            if (r_errCount != 8'hFF) begin
              r_errCount <= r_errCount + 8'd1;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_sValid <= '0;
          r_mReady <= 1'b0;
          r_mErr   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_valid = r_sValid;
  assign bus.s_addr  = r_addr;
  assign bus.s_wdata = r_wdata;
  assign bus.s_wstrb = r_wstrb;
  assign bus.m_ready = r_mReady;
  assign bus.m_err   = r_mErr;
  assign bus.m_rdata = r_mRdata;
  assign err_count   = r_errCount;
  assign err_addr    = r_errAddr;

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Parametrised memory-bus interconnect between the single rv32im CPU master (valid/ready, wstrb, 32-bit addr/data) and N memory-mapped slaves (BRAM, SPI NOR, PSRAM/cache, UART, sysregs, iomem).
- Replaces the hand-written per-slave valid/ready/rdata glue in the SoC top with one registered decoder.
- Adds per-region base/mask decode, read-only region protection, unmapped-address error response, per-transaction timeout, and error status.

Parameters:
- NUM_SLAVES, 6, number of slave ports (1..16).
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; wstrb is DATA_WIDTH/8.
- SLAVE_BASE, all zero, packed NUM_SLAVES*ADDR_WIDTH region base addresses (slave i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]).
- SLAVE_MASK, all zero, packed NUM_SLAVES*ADDR_WIDTH masks. Slave i matches when (m_addr & MASK_i) == BASE_i.
- SLAVE_RO, 0, NUM_SLAVES-bit mask; bit set means writes to that region are rejected.
- TIMEOUT_CYCLES, 1024, ACTIVE-state cycle limit; 0 disables the timeout.
- ERR_RDATA, 32'h0000_0000, rdata returned on error responses.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- m_valid  in  1  master request.
- m_ready  out  1  one-cycle response strobe.
- m_addr  in  ADDR_WIDTH  byte address.
- m_wdata  in  DATA_WIDTH  write data.
- m_wstrb  in  DATA_WIDTH/8  byte strobes; nonzero means write.
- m_rdata  out  DATA_WIDTH  registered read data.
- m_err  out  1  error qualifier, valid with m_ready.
- s_valid  out  NUM_SLAVES  one-hot slave request.
- s_ready  in  NUM_SLAVES  slave completion.
- s_addr  out  ADDR_WIDTH  registered copy of m_addr.
- s_wdata  out  DATA_WIDTH  registered copy of m_wdata.
- s_wstrb  out  DATA_WIDTH/8  registered copy of m_wstrb.
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- err_count  out  8  saturating error counter.
- err_addr  out  ADDR_WIDTH  address of the most recent error.

Behaviour:
- Reset (async, resetn=0): state IDLE; s_valid=0; m_ready=0; m_err=0; m_rdata=0; s_addr, s_wdata, s_wstrb=0; err_count=0; err_addr=0; timeout counter=0.
- IDLE:
  - On m_valid, decode m_addr. Lowest-index matching slave wins.
  - Latch addr, wdata, wstrb and the selected index.
  - No match, or write (|m_wstrb) to a SLAVE_RO region: go to RESP with error. s_valid is never asserted.
  - Otherwise: go to ACTIVE.
- ACTIVE:
  - s_valid[sel]=1; all other bits 0.
  - When s_ready[sel]=1: capture s_rdata[sel] into m_rdata, drop s_valid, go to RESP with m_err=0.
  - s_ready of unselected slaves is ignored.
  - The timeout counter increments each ACTIVE cycle. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without s_ready, drop s_valid and go to RESP with error.
- RESP:
  - m_ready=1 for exactly one cycle.
  - m_rdata = captured data, or ERR_RDATA on error.
  - Return to IDLE.
  - The master deasserts m_valid or presents a new request the cycle after m_ready. The decoder does not sample m_valid in RESP.
- Error side effects, applied in the RESP cycle: err_addr <= latched address; err_count increments and saturates at 255.
- Latency:
  - Mapped access: m_ready arrives 2 cycles after s_ready[sel], counting from m_valid: IDLE→ACTIVE, then ACTIVE→RESP.
  - A 1-cycle slave gives m_ready 3 cycles after m_valid.
  - Error from decode gives m_ready 2 cycles after m_valid.
- A late s_ready from a timed-out slave, arriving in IDLE or RESP, is ignored and never produces a spurious m_ready.
- Asynchronous reset asserted mid-transaction immediately clears s_valid and m_ready and aborts the transaction.
- Overlapping regions are legal; lowest index has priority.

Decomposition:
- Package mem_bus_pkg holds:
  - state enum {IDLE, ACTIVE, RESP};
  - localparams for the default SoC memory map (BRAM, SPI NOR, PSRAM, UART, CPU_FREQ);
  - function region_match(addr, base, mask).
- Sub-module mem_bus_addr_match: combinational priority decode producing hit, index and ro_violation from m_addr, m_wstrb and the parameters.
- FSM, counters and datapath registers live in mem_bus_decoder.

Test Plan:
- Slave 0 = BRAM (base 0, mask 0xFFFF_0000), 1-cycle ready; read 0x0000_0010 returning 0xDEAD_BEEF → s_valid[0] for 1 cycle; m_ready 3 cycles after m_valid; m_rdata=0xDEAD_BEEF; m_err=0.
- Write 0x1234_5678, wstrb=4'b0011, to the slave 2 region with 5-cycle ready → s_wdata/s_wstrb stable for all 5 cycles; single m_ready; m_err=0.
- Read unmapped 0xF000_0000 → no s_valid bit ever set; m_ready 2 cycles after m_valid; m_err=1; m_rdata=ERR_RDATA; err_addr=0xF000_0000; err_count=1.
- Write to a SLAVE_RO region (SPI NOR) → error response as above; s_valid stays 0.
- TIMEOUT_CYCLES=16, slave never ready → s_valid high exactly 16 cycles then drops; m_err=1. s_ready pulsed 3 cycles later → no m_ready.
- Assert resetn=0 mid-ACTIVE → s_valid and m_ready go to 0 immediately. 256+ errors → err_count holds at 255.
